// File: rtl/beep_sequencer_pkg.sv
// Shared encodings for the beep sequencer: FSM states, source codes,
// default alarm length, timer load values and the state-to-output decode.
package beep_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_ON  = 3'd1,
    ST_ON       = 3'd2,
    ST_LOAD_OFF = 3'd3,
    ST_OFF      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'b00,
    SRC_CHIME = 2'b01,
    SRC_ALARM = 2'b10
  } src_t;

  localparam int ALARM_BURSTS_DEF = 30;

  // Values the companion 3-bit timer loads for the ON and OFF periods.
  localparam logic [2:0] T1_ON  = 3'd2;
  localparam logic [2:0] T1_OFF = 3'd1;

  typedef struct packed {
    logic beep;
    logic tload;
    logic tsel;
    logic tclr;
    logic busy;
  } outs_t;

  function automatic outs_t decode_outputs(input state_t st);
    outs_t o;
    o.beep  = 1'b0;
    o.tload = 1'b0;
    o.tsel  = 1'b0;
    o.tclr  = 1'b0;
    o.busy  = 1'b1;
    case (st)
      ST_IDLE: begin
        o.tclr = 1'b1;
        o.busy = 1'b0;
      end
      ST_LOAD_ON: begin
        o.tload = 1'b1;
        o.tsel  = 1'b1;
      end
      ST_ON: begin
        o.beep = 1'b1;
      end
      ST_LOAD_OFF: begin
        o.tload = 1'b1;
      end
      ST_OFF: begin
        o.beep = 1'b0;
      end
      default: begin
        o.tclr = 1'b1;
        o.busy = 1'b0;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/beep_sequencer.sv
// Beep burst sequencer: arbitrates hourly chime and alarm requests and drives
// the on/off timer controls and buzzer enable from registered state only.
module beep_sequencer
  import beep_sequencer_pkg::*;
#(
  parameter int CNT_W        = 5,
  parameter int ALARM_BURSTS = ALARM_BURSTS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       chime_req,
  input  logic [3:0] chime_cnt,
  input  logic       alarm_req,
  input  logic       alarm_stop,
  input  logic       tdone,
  output logic       tload,
  output logic       tsel,
  output logic       tclr,
  output logic       beep,
  output logic       busy,
  output logic [1:0] src
);

  localparam logic [CNT_W-1:0] REM_ALARM = CNT_W'(ALARM_BURSTS);
  localparam logic [CNT_W-1:0] REM_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] REM_ZERO  = CNT_W'(1'b0);

  state_t             state_r;
  state_t             state_next_s;
  src_t               src_r;
  src_t               src_next_s;
  logic [CNT_W-1:0]   rem_r;
  logic [CNT_W-1:0]   rem_next_s;
  logic               pend_r;
  logic               pend_next_s;
  logic               alarm_req_s;
  logic               pend_eff_s;
  outs_t              outs_r;

  // Next-state, burst counter, source and pending-alarm decisions.
  always_comb begin
    state_next_s = state_r;
    rem_next_s   = rem_r;
    src_next_s   = src_r;
    // A stop in the same cycle as a request suppresses the request.
    alarm_req_s  = alarm_req & ~alarm_stop;
    pend_eff_s   = pend_r & ~alarm_stop;
    pend_next_s  = pend_eff_s | (alarm_req_s & (src_r == SRC_CHIME));

    if (!en) begin
      state_next_s = ST_IDLE;
      rem_next_s   = REM_ZERO;
      src_next_s   = SRC_NONE;
      pend_next_s  = 1'b0;
    end else if (alarm_stop && (src_r == SRC_ALARM)) begin
      state_next_s = ST_IDLE;
      rem_next_s   = REM_ZERO;
      src_next_s   = SRC_NONE;
      pend_next_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (alarm_req_s || pend_eff_s) begin
            state_next_s = ST_LOAD_ON;
            rem_next_s   = REM_ALARM;
            src_next_s   = SRC_ALARM;
            pend_next_s  = 1'b0;
          end else if (chime_req && (chime_cnt != 4'd0)) begin
            state_next_s = ST_LOAD_ON;
            rem_next_s   = CNT_W'(chime_cnt);
            src_next_s   = SRC_CHIME;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_LOAD_ON: begin
          state_next_s = ST_ON;
        end
        ST_ON: begin
          if (tdone) begin
            if (rem_r != REM_ZERO) begin
              rem_next_s = rem_r - REM_ONE;
            end else begin
              rem_next_s = REM_ZERO;
            end
            if (rem_r <= REM_ONE) begin
              state_next_s = ST_IDLE;
              src_next_s   = SRC_NONE;
            end else begin
              state_next_s = ST_LOAD_OFF;
            end
          end else begin
            state_next_s = ST_ON;
          end
        end
        ST_LOAD_OFF: begin
          state_next_s = ST_OFF;
        end
        ST_OFF: begin
          if (tdone) begin
            // A waiting alarm takes over from a chime at the end of its gap.
            if ((src_r == SRC_CHIME) && (pend_eff_s || alarm_req_s)) begin
              rem_next_s  = REM_ALARM;
              src_next_s  = SRC_ALARM;
              pend_next_s = 1'b0;
            end else begin
              rem_next_s  = rem_r;
            end
            state_next_s = ST_LOAD_ON;
          end else begin
            state_next_s = ST_OFF;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
          rem_next_s   = REM_ZERO;
          src_next_s   = SRC_NONE;
          pend_next_s  = 1'b0;
        end
      endcase
    end
  end

  // State, counter and output registers; outputs are pre-decoded from next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      src_r   <= SRC_NONE;
      rem_r   <= REM_ZERO;
      pend_r  <= 1'b0;
      outs_r  <= decode_outputs(ST_IDLE);
    end else begin
      state_r <= state_next_s;
      src_r   <= src_next_s;
      rem_r   <= rem_next_s;
      pend_r  <= pend_next_s;
      outs_r  <= decode_outputs(state_next_s);
    end
  end

  assign beep  = outs_r.beep;
  assign tload = outs_r.tload;
  assign tsel  = outs_r.tsel;
  assign tclr  = outs_r.tclr;
  assign busy  = outs_r.busy;
  assign src   = src_r;

endmodule

// File: tb/tb_beep_sequencer.sv
// Self-checking bench for beep_sequencer with a behavioural 3-bit timer and
// a queue of expected per-cycle outputs derived from the burst timing rules.
module tb_beep_sequencer;
  import beep_sequencer_pkg::*;

  typedef struct packed {
    logic       en;
    logic       chime_req;
    logic [3:0] chime_cnt;
    logic       alarm_req;
    logic       alarm_stop;
  } stim_t;

  typedef struct packed {
    logic       beep;
    logic       busy;
    logic [1:0] src;
    logic       tload;
    logic       tsel;
    logic       tclr;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       chime_req = 1'b0;
  logic [3:0] chime_cnt = 4'd0;
  logic       alarm_req = 1'b0;
  logic       alarm_stop = 1'b0;
  logic       tdone;
  logic       tload, tsel, tclr, beep, busy;
  logic [1:0] src;
  logic [2:0] tcnt;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  string phase = "reset";
  exp_t exp_q[$];

  beep_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .chime_req(chime_req), .chime_cnt(chime_cnt),
    .alarm_req(alarm_req), .alarm_stop(alarm_stop), .tdone(tdone),
    .tload(tload), .tsel(tsel), .tclr(tclr), .beep(beep), .busy(busy), .src(src)
  );

  always #5 clk = ~clk;

  // Companion on/off timer: clear, load, or count down to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tcnt <= 3'd0;
    else if (tclr) tcnt <= 3'd0;
    else if (tload) tcnt <= tsel ? T1_ON : T1_OFF;
    else if (tcnt != 3'd0) tcnt <= tcnt - 3'd1;
    else tcnt <= 3'd0;
  end
  assign tdone = (tcnt == 3'd0);

  function automatic exp_t mk(input logic b, input logic bz, input logic [1:0] s,
                              input logic tl, input logic ts, input logic tc);
    exp_t e;
    e.beep = b; e.busy = bz; e.src = s; e.tload = tl; e.tsel = ts; e.tclr = tc;
    return e;
  endfunction

  function automatic stim_t mk_s(input logic e, input logic cr, input logic [3:0] cc,
                                 input logic ar, input logic as);
    stim_t s;
    s.en = e; s.chime_req = cr; s.chime_cnt = cc; s.alarm_req = ar; s.alarm_stop = as;
    return s;
  endfunction

  function automatic exp_t e_idle();
    return mk(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic exp_t e_lon(input logic [1:0] s);
    return mk(1'b0, 1'b1, s, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic exp_t e_on(input logic [1:0] s);
    return mk(1'b1, 1'b1, s, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t e_loff(input logic [1:0] s);
    return mk(1'b0, 1'b1, s, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic exp_t e_off(input logic [1:0] s);
    return mk(1'b0, 1'b1, s, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic check_outs(input exp_t e);
    checks++;
    if (beep !== e.beep || busy !== e.busy || src !== e.src || tload !== e.tload ||
        tsel !== e.tsel || tclr !== e.tclr) begin
      failures++;
      $display("FAIL %s cycle=%0d got beep=%b busy=%b src=%b tload=%b tsel=%b tclr=%b want beep=%b busy=%b src=%b tload=%b tsel=%b tclr=%b",
               phase, cyc, beep, busy, src, tload, tsel, tclr,
               e.beep, e.busy, e.src, e.tload, e.tsel, e.tclr);
    end
  endtask

  task automatic tick(input stim_t s);
    exp_t e;
    en = s.en; chime_req = s.chime_req; chime_cnt = s.chime_cnt;
    alarm_req = s.alarm_req; alarm_stop = s.alarm_stop;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_outs(e);
    end
  endtask

  task automatic drain();
    while (exp_q.size() != 0) tick(mk_s(1'b1, 1'b0, 4'd0, 1'b0, 1'b0));
  endtask

  // Expected outputs for n bursts from the LOAD_ON cycle through return to idle.
  task automatic push_bursts(input int n, input logic [1:0] s);
    exp_q.push_back(e_lon(s));
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 3; k++) exp_q.push_back(e_on(s));
      if (b < n - 1) begin
        exp_q.push_back(e_loff(s));
        exp_q.push_back(e_off(s));
        exp_q.push_back(e_off(s));
        exp_q.push_back(e_lon(s));
      end
    end
    exp_q.push_back(e_idle());
  endtask

  vec_t  vecs[7];
  stim_t idle_s;

  initial begin
    idle_s = mk_s(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    vecs[0] = '{s: idle_s,                                     e: e_idle()};
    vecs[1] = '{s: mk_s(1'b1, 1'b1, 4'd0, 1'b0, 1'b0),         e: e_idle()};
    vecs[2] = '{s: mk_s(1'b1, 1'b0, 4'd0, 1'b1, 1'b1),         e: e_idle()};
    vecs[3] = '{s: idle_s,                                     e: e_idle()};
    vecs[4] = '{s: mk_s(1'b0, 1'b0, 4'd0, 1'b1, 1'b0),         e: e_idle()};
    vecs[5] = '{s: mk_s(1'b0, 1'b1, 4'd5, 1'b0, 1'b0),         e: e_idle()};
    vecs[6] = '{s: idle_s,                                     e: e_idle()};

    // Reset held low with clocks running.
    repeat (3) @(posedge clk);
    #1;
    check_outs(e_idle());
    rst = 1'b1;
    phase = "idle_after_reset";
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(e_idle());
      tick(idle_s);
    end

    phase = "idle_vectors";
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(vecs[i].e);
      tick(vecs[i].s);
    end

    phase = "chime3";
    push_bursts(3, SRC_CHIME);
    tick(mk_s(1'b1, 1'b1, 4'd3, 1'b0, 1'b0));
    drain();

    phase = "alarm_stop";
    exp_q.push_back(e_lon(SRC_ALARM));
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 3; k++) exp_q.push_back(e_on(SRC_ALARM));
      exp_q.push_back(e_loff(SRC_ALARM));
      if (b == 0) begin
        exp_q.push_back(e_off(SRC_ALARM));
        exp_q.push_back(e_off(SRC_ALARM));
        exp_q.push_back(e_lon(SRC_ALARM));
      end
    end
    tick(mk_s(1'b1, 1'b0, 4'd0, 1'b1, 1'b0));
    for (int i = 0; i < 11; i++) tick(idle_s);
    exp_q.push_back(e_idle());
    tick(mk_s(1'b1, 1'b0, 4'd0, 1'b0, 1'b1));
    for (int i = 0; i < 8; i++) exp_q.push_back(e_idle());
    drain();

    phase = "chime12_preempt";
    exp_q.push_back(e_lon(SRC_CHIME));
    for (int k = 0; k < 3; k++) exp_q.push_back(e_on(SRC_CHIME));
    exp_q.push_back(e_loff(SRC_CHIME));
    exp_q.push_back(e_off(SRC_CHIME));
    exp_q.push_back(e_off(SRC_CHIME));
    exp_q.push_back(e_lon(SRC_CHIME));
    tick(mk_s(1'b1, 1'b1, 4'd12, 1'b0, 1'b0));
    for (int i = 0; i < 7; i++) tick(idle_s);
    exp_q.push_back(e_on(SRC_CHIME));
    tick(idle_s);
    exp_q.push_back(e_on(SRC_CHIME));
    tick(mk_s(1'b1, 1'b0, 4'd0, 1'b1, 1'b0));
    exp_q.push_back(e_on(SRC_CHIME));
    exp_q.push_back(e_loff(SRC_CHIME));
    exp_q.push_back(e_off(SRC_CHIME));
    exp_q.push_back(e_off(SRC_CHIME));
    push_bursts(ALARM_BURSTS_DEF, SRC_ALARM);
    drain();

    phase = "alarm_beats_chime";
    exp_q.push_back(e_lon(SRC_ALARM));
    for (int k = 0; k < 3; k++) exp_q.push_back(e_on(SRC_ALARM));
    exp_q.push_back(e_loff(SRC_ALARM));
    tick(mk_s(1'b1, 1'b1, 4'd5, 1'b1, 1'b0));
    for (int i = 0; i < 4; i++) tick(idle_s);
    exp_q.push_back(e_idle());
    tick(mk_s(1'b1, 1'b0, 4'd0, 1'b0, 1'b1));
    for (int i = 0; i < 10; i++) exp_q.push_back(e_idle());
    drain();

    phase = "en_low_mid_on";
    exp_q.push_back(e_lon(SRC_CHIME));
    exp_q.push_back(e_on(SRC_CHIME));
    tick(mk_s(1'b1, 1'b1, 4'd3, 1'b0, 1'b0));
    tick(idle_s);
    exp_q.push_back(e_idle());
    tick(mk_s(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    exp_q.push_back(e_idle());
    tick(mk_s(1'b0, 1'b0, 4'd0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(e_idle());
      tick(mk_s(1'b0, 1'b0, 4'd0, 1'b0, 1'b0));
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(e_idle());
    drain();

    phase = "async_reset_mid_on";
    exp_q.push_back(e_lon(SRC_CHIME));
    exp_q.push_back(e_on(SRC_CHIME));
    tick(mk_s(1'b1, 1'b1, 4'd4, 1'b0, 1'b0));
    tick(idle_s);
    #2;
    rst = 1'b0;
    #1;
    check_outs(e_idle());
    @(posedge clk);
    #1;
    check_outs(e_idle());
    rst = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(e_idle());
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
